ts_gen_mx: RTL and testbench

Multi-lane, parametrised training-set generator for the LTSSM simulation model. It builds TS1/TS2 ordered sets for `NUM_LANES` lanes from the FSM state/sub-state and from link/lane numbers supplied by the TS analyser (TSA). It drives one 128-bit TS per lane into per-lane TX FIFOs, counts transmitted sets per lane, and reports when enough have been sent. It sits between the LTSSM FSM/TSA and the lane TX FIFOs.

---
 rtl/ts_gen_mx_if.sv | 50 +++++
 rtl/ts_gen_mx.sv | 199 +++++++++++++++++++
 tb/tb_ts_gen_mx.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ts_gen_mx_if.sv
// ---------------------------------------------------------------------------
// ts_gen_mx_if
// Bundles the LTSSM FSM / TS analyser request signals and the per-lane TX
// FIFO side of the training-set generator.
//   master : FSM/TSA/FIFO side (drives requests, state info, backpressure)
//   slave  : the generator (drives acks, TS words, strobes, progress flags)
// Signals:
//   ts_info[7:4] state, ts_info[3:0] sub-state; ts_update / ts_update_ack;
//   ts_stop; mode (1 = DSP, 0 = USP); lane_en; lane_rev;
//   rcv_link_num(+_vld), rcv_lane_num(+_vld, lane l at [8l+7:8l]);
//   tsa_update_ack; tx_fifo_full; ts_valid; ts (lane l at [128l+127:128l]);
//   sent_enough_lane; sent_enough.
// ---------------------------------------------------------------------------
interface ts_gen_mx_if #(
  parameter int NUM_LANES = 4
);
  logic [7:0]               ts_info;
  logic                     ts_update;
  logic                     ts_update_ack;
  logic                     ts_stop;
  logic                     mode;
  logic [NUM_LANES-1:0]     lane_en;
  logic                     lane_rev;
  logic [7:0]               rcv_link_num;
  logic                     rcv_link_num_vld;
  logic [8*NUM_LANES-1:0]   rcv_lane_num;
  logic [NUM_LANES-1:0]     rcv_lane_num_vld;
  logic                     tsa_update_ack;
  logic [NUM_LANES-1:0]     tx_fifo_full;
  logic [NUM_LANES-1:0]     ts_valid;
  logic [128*NUM_LANES-1:0] ts;
  logic [NUM_LANES-1:0]     sent_enough_lane;
  logic                     sent_enough;

  modport master (
    output ts_info, ts_update, ts_stop, mode, lane_en, lane_rev,
           rcv_link_num, rcv_link_num_vld, rcv_lane_num, rcv_lane_num_vld,
           tx_fifo_full,
    input  ts_update_ack, tsa_update_ack, ts_valid, ts,
           sent_enough_lane, sent_enough
  );

  modport slave (
    input  ts_info, ts_update, ts_stop, mode, lane_en, lane_rev,
           rcv_link_num, rcv_link_num_vld, rcv_lane_num, rcv_lane_num_vld,
           tx_fifo_full,
    output ts_update_ack, tsa_update_ack, ts_valid, ts,
           sent_enough_lane, sent_enough
  );
endinterface

// File: rtl/ts_gen_mx.sv
// ---------------------------------------------------------------------------
// ts_gen_mx
// Multi-lane TS1/TS2 ordered-set generator for the LTSSM model. On an FSM
// update edge or a TSA valid edge it loads new per-lane 128-bit training
// sets (symbol 0 in the MSByte), then streams them into the lane TX FIFOs,
// counting sent sets per lane against a state-dependent target.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : ts_gen_mx_if.slave (requests, lane numbers, FIFO side)
// ---------------------------------------------------------------------------
module ts_gen_mx #(
  parameter int NUM_LANES           = 4,
  parameter int CNT_W               = 16,
  parameter int TX_NUM_POLL_ACT2CFG = 1024,
  parameter int TX_NUM_POLL2CFG     = 16,
  parameter int TX_NUM_CFG_C2I      = 16,
  parameter int RX_NUM_CFG_GENERAL  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  ts_gen_mx_if.slave bus
);
  localparam logic [3:0] ST_POLL      = 4'h2;
  localparam logic [3:0] ST_CFG       = 4'h3;
  localparam logic [3:0] POLL_ACTIVE  = 4'h0;
  localparam logic [3:0] CFG_LW_START = 4'h0;
  localparam logic [3:0] CFG_LW_ACC   = 4'h1;
  localparam logic [3:0] CFG_LN_WAIT  = 4'h2;
  localparam logic [3:0] CFG_COMPLETE = 4'h4;
  localparam logic [7:0] COM          = 8'hBC;
  localparam logic [7:0] PADG12       = 8'hF7;
  localparam logic [7:0] LINK_NUM     = 8'h01;
  localparam logic [7:0] TS1_IDTFR    = 8'h4A;
  localparam logic [7:0] TS2_IDTFR    = 8'h45;
  localparam logic [5:0] RATE_SUPPORT = 6'h02;
  localparam logic       MODE_DSP     = 1'b1;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, TX = 2'd2} state_t;

  state_t                   state_q, state_nx;
  logic                     load_entry, in_load, tx_go;
  logic                     ts_update_p1, tsa_any_p1, tsa_any;
  logic                     upd_ev, tsa_ev, any_ev;
  logic                     upd_ack_q, tsa_ack_q;
  logic                     link_acq;
  logic [NUM_LANES-1:0]     lane_acq;
  logic [7:0]               link_num_q;
  logic [8*NUM_LANES-1:0]   lane_num_q;
  logic [NUM_LANES-1:0]     lane_en_q, valid_q, se_lane_q;
  logic [CNT_W-1:0]         tgt_q, tgt_nx;
  logic [CNT_W-1:0]         cnt_q [NUM_LANES];
  logic [128*NUM_LANES-1:0] ts_q, ts_nx;
  logic [3:0]               st_f, sub_f;
  logic                     is_poll, is_cfg, is_dsp, use_ts2;
  logic [7:0]               ident, sym1, sym2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign st_f    = bus.ts_info[7:4];
  assign sub_f   = bus.ts_info[3:0];
  assign is_poll = (st_f == ST_POLL);
  assign is_cfg  = (st_f == ST_CFG);
  assign is_dsp  = (bus.mode == MODE_DSP);
  assign use_ts2 = (is_poll && sub_f != POLL_ACTIVE) || (is_cfg && sub_f == CFG_COMPLETE);

  assign tsa_any = bus.rcv_link_num_vld | (|bus.rcv_lane_num_vld);
  assign upd_ev  = bus.ts_update & ~ts_update_p1;
  assign tsa_ev  = tsa_any & ~tsa_any_p1;
  assign any_ev  = upd_ev | tsa_ev;

  always_comb begin
    state_nx   = state_q;
    load_entry = 1'b0;
    in_load    = 1'b0;
    tx_go      = 1'b0;
    case (state_q)
      IDLE: if (any_ev) state_nx = LOAD;
      LOAD: state_nx = TX;
      TX: begin
        // An event wins over ts_stop.
        if (any_ev)           state_nx = LOAD;
        else if (bus.ts_stop) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    load_entry = (state_q != LOAD) && (state_nx == LOAD);
    in_load    = (state_q == LOAD);
    // Strobe only while staying in TX so IDLE/LOAD cycles never carry a valid.
    tx_go      = (state_q == TX) && (state_nx == TX);
  end

  // Symbol build for the LOAD cycle; lanes outside POLL/CFG keep their words.
  always_comb begin
    ts_nx  = ts_q;
    tgt_nx = tgt_q;
    ident  = use_ts2 ? TS2_IDTFR : TS1_IDTFR;
    sym1   = PADG12;
    sym2   = PADG12;
    if (is_poll)
      tgt_nx = (sub_f == POLL_ACTIVE) ? CNT_W'(TX_NUM_POLL_ACT2CFG) : CNT_W'(TX_NUM_POLL2CFG);
    else if (is_cfg)
      tgt_nx = (sub_f == CFG_COMPLETE) ? CNT_W'(TX_NUM_CFG_C2I) : CNT_W'(RX_NUM_CFG_GENERAL);
    for (int l = 0; l < NUM_LANES; l++) begin
      sym1 = ts_q[128*l+119 -: 8];
      sym2 = ts_q[128*l+111 -: 8];
      if (is_poll) begin
        sym1 = PADG12;
        sym2 = PADG12;
      end else if (is_cfg) begin
        if (sub_f == CFG_LW_START) begin
          sym1 = is_dsp ? LINK_NUM : PADG12;
          sym2 = PADG12;
        end else if (sub_f == CFG_LW_ACC && is_dsp) begin
          sym1 = LINK_NUM;
          sym2 = bus.lane_rev ? 8'(NUM_LANES - 1 - l) : 8'(l);
        end else if (sub_f == CFG_LW_ACC || (sub_f == CFG_LN_WAIT && !is_dsp)) begin
          sym1 = (sub_f == CFG_LN_WAIT) ? LINK_NUM : (link_acq ? link_num_q : PADG12);
          sym2 = lane_acq[l] ? lane_num_q[8*l +: 8] : PADG12;
        end
        if (!bus.lane_en[l]) begin
          sym1 = PADG12;
          sym2 = PADG12;
        end
      end
      if (is_poll || is_cfg)
        ts_nx[128*l +: 128] = {COM, sym1, sym2, 8'hFF, {2'b00, RATE_SUPPORT}, 8'h00, {10{ident}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ts_update_p1 <= 1'b0;
      tsa_any_p1   <= 1'b0;
      upd_ack_q    <= 1'b0;
      tsa_ack_q    <= 1'b0;
      link_acq     <= 1'b0;
      lane_acq     <= '0;
      link_num_q   <= '0;
      lane_num_q   <= '0;
      lane_en_q    <= '0;
      valid_q      <= '0;
      se_lane_q    <= '0;
      tgt_q        <= '0;
      ts_q         <= '0;
      for (int l = 0; l < NUM_LANES; l++) cnt_q[l] <= '0;
    end else begin
      state_q      <= state_nx;
      ts_update_p1 <= bus.ts_update;
      tsa_any_p1   <= tsa_any;
      upd_ack_q    <= load_entry & upd_ev;
      tsa_ack_q    <= load_entry & tsa_ev;

      // Acquired link/lane numbers only live while the FSM stays in CFG.
      if (st_f != ST_CFG) begin
        link_acq <= 1'b0;
        lane_acq <= '0;
      end else if (load_entry && tsa_ev) begin
        if (bus.rcv_link_num_vld) begin
          link_acq   <= 1'b1;
          link_num_q <= bus.rcv_link_num;
        end
        for (int l = 0; l < NUM_LANES; l++) begin
          if (bus.rcv_lane_num_vld[l]) begin
            lane_acq[l]           <= 1'b1;
            lane_num_q[8*l +: 8]  <= bus.rcv_lane_num[8*l +: 8];
          end
        end
      end

      valid_q <= '0;
      if (in_load) begin
        lane_en_q <= bus.lane_en;
        ts_q      <= ts_nx;
        tgt_q     <= tgt_nx;
        se_lane_q <= '0;
        for (int l = 0; l < NUM_LANES; l++) cnt_q[l] <= '0;
      end else if (tx_go) begin
        for (int l = 0; l < NUM_LANES; l++) begin
          if (lane_en_q[l]) begin
            valid_q[l] <= ~bus.tx_fifo_full[l];
            if (!bus.tx_fifo_full[l]) cnt_q[l] <= sat_inc(cnt_q[l]);
            if (cnt_q[l] >= tgt_q)    se_lane_q[l] <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.ts_update_ack    = upd_ack_q;
  assign bus.tsa_update_ack   = tsa_ack_q;
  assign bus.ts_valid         = valid_q;
  assign bus.ts               = ts_q;
  assign bus.sent_enough_lane = se_lane_q;
  assign bus.sent_enough      = (|lane_en_q) && ((se_lane_q & lane_en_q) == lane_en_q);
endmodule

// File: tb/tb_ts_gen_mx.sv
// ---------------------------------------------------------------------------
// tb_ts_gen_mx
// Self-checking bench for ts_gen_mx: directed scenarios plus randomized
// requests/backpressure, compared each cycle against a behavioural model of
// the training-set rules (symbol tables, per-lane sent counts, targets).
// ---------------------------------------------------------------------------
module tb_ts_gen_mx;
  localparam int NL    = 4;
  localparam int T_ACT = 24;
  localparam int T_P2C = 16;
  localparam int T_C2I = 12;
  localparam int T_GEN = 8;
  localparam logic [7:0] COM = 8'hBC, PAD = 8'hF7, LINK = 8'h01;
  localparam logic [7:0] TS1 = 8'h4A, TS2 = 8'h45, RATE = 8'h02;
  localparam logic [3:0] S_POLL = 4'h2, S_CFG = 4'h3;
  localparam logic [3:0] POLL_ACTIVE = 4'h0, LW_START = 4'h0, LW_ACC = 4'h1;
  localparam logic [3:0] LN_WAIT = 4'h2, COMPLETE = 4'h4;
  localparam logic DSP = 1'b1, USP = 1'b0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ts_gen_mx_if #(.NUM_LANES(NL)) bus();

  ts_gen_mx #(
    .NUM_LANES(NL), .CNT_W(16),
    .TX_NUM_POLL_ACT2CFG(T_ACT), .TX_NUM_POLL2CFG(T_P2C),
    .TX_NUM_CFG_C2I(T_C2I), .RX_NUM_CFG_GENERAL(T_GEN)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0]   info_m;
  logic         mode_m, rev_m;
  logic [3:0]   en_m, se_m, lane_acq_m;
  logic         link_acq_m;
  logic [7:0]   link_m;
  logic [7:0]   lane_m [NL];
  logic [127:0] ts_m [NL];
  int           cnt_m [NL];
  int           tgt_m;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] ts_all();
    logic [511:0] r;
    r = '0;
    for (int l = 0; l < NL; l++) r[128*l +: 128] = ts_m[l];
    return r;
  endfunction

  function automatic logic se_all_exp();
    return (en_m != 4'b0) && ((se_m & en_m) == en_m);
  endfunction

  // Training set of lane l from the symbol tables; other states keep old word.
  function automatic logic [127:0] model_ts(input int l, input logic [127:0] old);
    logic [7:0]   s [16];
    logic [127:0] r;
    logic [3:0]   st, sb;
    st = info_m[7:4];
    sb = info_m[3:0];
    for (int k = 0; k < 16; k++) s[k] = old[127-8*k -: 8];
    if (st != S_POLL && st != S_CFG) return old;
    s[0] = COM; s[3] = 8'hFF; s[4] = RATE; s[5] = 8'h00;
    for (int k = 6; k < 16; k++)
      s[k] = ((st == S_POLL && sb != POLL_ACTIVE) || (st == S_CFG && sb == COMPLETE)) ? TS2 : TS1;
    if (st == S_POLL) begin
      s[1] = PAD; s[2] = PAD;
    end else begin
      if (sb == LW_START) begin
        s[1] = (mode_m == DSP) ? LINK : PAD;
        s[2] = PAD;
      end else if (sb == LW_ACC && mode_m == DSP) begin
        s[1] = LINK;
        s[2] = rev_m ? 8'(NL - 1 - l) : 8'(l);
      end else if (sb == LW_ACC && mode_m == USP) begin
        s[1] = link_acq_m ? link_m : PAD;
        s[2] = lane_acq_m[l] ? lane_m[l] : PAD;
      end else if (sb == LN_WAIT && mode_m == USP) begin
        s[1] = LINK;
        s[2] = lane_acq_m[l] ? lane_m[l] : PAD;
      end
      if (!en_m[l]) begin
        s[1] = PAD; s[2] = PAD;
      end
    end
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = s[k];
    return r;
  endfunction

  task automatic model_reset();
    for (int l = 0; l < NL; l++) begin
      ts_m[l]  = '0;
      cnt_m[l] = 0;
      lane_m[l] = '0;
    end
    en_m = '0; se_m = '0; lane_acq_m = '0; link_acq_m = 1'b0;
    link_m = '0; tgt_m = 0; info_m = '0; mode_m = 1'b0; rev_m = 1'b0;
  endtask

  task automatic check_outs(input string ph, input logic [3:0] exp_v,
                            input logic exp_uack, input logic exp_tack);
    chk({ph, "_valid"}, 512'(bus.ts_valid), 512'(exp_v));
    chk({ph, "_upd_ack"}, 512'(bus.ts_update_ack), 512'(exp_uack));
    chk({ph, "_tsa_ack"}, 512'(bus.tsa_update_ack), 512'(exp_tack));
    chk({ph, "_se_lane"}, 512'(bus.sent_enough_lane), 512'(se_m));
    chk({ph, "_se_all"}, 512'(bus.sent_enough), 512'(se_all_exp()));
    chk({ph, "_ts"}, bus.ts, ts_all());
  endtask

  task automatic do_event(input logic [7:0] info, input logic upd, input logic tsa,
                          input logic stop, input logic md, input logic rv,
                          input logic [3:0] en, input logic lvld, input logic [7:0] lnum,
                          input logic [3:0] lnvld, input logic [31:0] lnums);
    bus.ts_info = info; bus.mode = md; bus.lane_rev = rv; bus.lane_en = en;
    bus.ts_update = upd; bus.ts_stop = stop;
    bus.rcv_link_num = lnum; bus.rcv_lane_num = lnums;
    bus.rcv_link_num_vld = tsa & lvld;
    bus.rcv_lane_num_vld = tsa ? lnvld : 4'b0;
    tick();
    info_m = info; mode_m = md; rev_m = rv;
    if (info[7:4] != S_CFG) begin
      link_acq_m = 1'b0;
      lane_acq_m = '0;
    end else if (tsa) begin
      if (lvld) begin
        link_acq_m = 1'b1;
        link_m = lnum;
      end
      for (int l = 0; l < NL; l++)
        if (lnvld[l]) begin
          lane_acq_m[l] = 1'b1;
          lane_m[l] = lnums[8*l +: 8];
        end
    end
    check_outs("entry", 4'b0, upd, tsa);
    bus.ts_update = 1'b0; bus.ts_stop = 1'b0;
    bus.rcv_link_num_vld = 1'b0; bus.rcv_lane_num_vld = '0;
    tick();
    en_m = en;
    for (int l = 0; l < NL; l++) begin
      ts_m[l]  = model_ts(l, ts_m[l]);
      cnt_m[l] = 0;
    end
    se_m = '0;
    if (info[7:4] == S_POLL)     tgt_m = (info[3:0] == POLL_ACTIVE) ? T_ACT : T_P2C;
    else if (info[7:4] == S_CFG) tgt_m = (info[3:0] == COMPLETE) ? T_C2I : T_GEN;
    check_outs("load", 4'b0, 1'b0, 1'b0);
  endtask

  task automatic tx_run(input int n, input int pct, input logic [3:0] force_full);
    logic [3:0] full;
    for (int i = 0; i < n; i++) begin
      full = force_full;
      for (int l = 0; l < NL; l++)
        if (int'($urandom_range(99)) < pct) full[l] = 1'b1;
      bus.tx_fifo_full = full;
      tick();
      for (int l = 0; l < NL; l++)
        if (en_m[l]) begin
          if (cnt_m[l] >= tgt_m) se_m[l] = 1'b1;
          if (!full[l] && cnt_m[l] < 65535) cnt_m[l]++;
        end
      check_outs("tx", en_m & ~full, 1'b0, 1'b0);
    end
    bus.tx_fifo_full = '0;
  endtask

  task automatic idle_run(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tx_fifo_full = 4'($urandom);
      tick();
      check_outs("idle", 4'b0, 1'b0, 1'b0);
    end
    bus.tx_fifo_full = '0;
  endtask

  task automatic stop_now();
    bus.ts_stop = 1'b1;
    tick();
    check_outs("stop", 4'b0, 1'b0, 1'b0);
    bus.ts_stop = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] infos [8];
    logic [7:0] inf;
    logic       upd, tsa, lvld;
    logic [3:0] lnvld, en;
    infos = '{8'h20, 8'h21, 8'h30, 8'h31, 8'h32, 8'h34, 8'h33, 8'h10};

    bus.ts_info = '0; bus.ts_update = 1'b0; bus.ts_stop = 1'b0; bus.mode = DSP;
    bus.lane_en = '0; bus.lane_rev = 1'b0; bus.rcv_link_num = '0;
    bus.rcv_link_num_vld = 1'b0; bus.rcv_lane_num = '0; bus.rcv_lane_num_vld = '0;
    bus.tx_fifo_full = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 4'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle_run(2);

    // POLL active, all lanes, never full: sent_enough at cycle 3+T
    do_event({S_POLL, POLL_ACTIVE}, 1, 0, 0, DSP, 0, 4'hF, 0, 8'h00, 4'h0, 32'h0);
    tx_run(T_ACT + 4, 0, 4'b0);

    // CFG LW_ACC, DSP, reversed lanes
    do_event({S_CFG, LW_ACC}, 1, 0, 0, DSP, 1, 4'hF, 0, 8'h00, 4'h0, 32'h0);
    tx_run(T_GEN + 3, 10, 4'b0);

    // CFG LW_ACC, USP: pads first, then TSA acquisition
    do_event({S_CFG, LW_ACC}, 1, 0, 0, USP, 0, 4'hF, 0, 8'h00, 4'h0, 32'h0);
    tx_run(3, 0, 4'b0);
    do_event({S_CFG, LW_ACC}, 0, 1, 0, USP, 0, 4'hF, 1, 8'h05, 4'b0011, 32'h03020100);
    tx_run(T_GEN + 3, 0, 4'b0);

    // Lane 2 held full for 10 cycles mid-TX
    do_event({S_POLL, POLL_ACTIVE}, 1, 0, 0, DSP, 0, 4'hF, 0, 8'h00, 4'h0, 32'h0);
    tx_run(5, 0, 4'b0);
    tx_run(10, 0, 4'b0100);
    tx_run(T_ACT + 12, 0, 4'b0);

    // Lanes 1/3 disabled
    do_event({S_CFG, LW_START}, 1, 0, 0, DSP, 0, 4'b0101, 0, 8'h00, 4'h0, 32'h0);
    tx_run(T_GEN + 6, 20, 4'b0);

    // Update edge together with stop, then stop alone
    do_event({S_POLL, 4'h1}, 1, 0, 1, DSP, 0, 4'hF, 0, 8'h00, 4'h0, 32'h0);
    tx_run(4, 0, 4'b0);
    stop_now();
    idle_run(4);

    // Reset for part of a cycle mid-TX
    do_event({S_POLL, POLL_ACTIVE}, 1, 0, 0, DSP, 0, 4'hF, 0, 8'h00, 4'h0, 32'h0);
    tx_run(5, 0, 4'b0);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_outs("rst_mid", 4'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle_run(5);
    do_event({S_CFG, COMPLETE}, 1, 0, 0, DSP, 0, 4'hF, 0, 8'h00, 4'h0, 32'h0);
    tx_run(T_C2I + 3, 0, 4'b0);

    // Randomized requests and backpressure
    for (int it = 0; it < 14; it++) begin
      inf   = infos[$urandom_range(7)];
      upd   = 1'($urandom);
      tsa   = 1'($urandom);
      if (!upd && !tsa) upd = 1'b1;
      lvld  = 1'($urandom);
      lnvld = 4'($urandom);
      if (!lvld && lnvld == 4'b0) lvld = 1'b1;
      en    = (it % 5 == 4) ? 4'b0 : 4'($urandom);
      do_event(inf, upd, tsa, 0, 1'($urandom), 1'($urandom), en, lvld,
               8'($urandom), lnvld, $urandom);
      tx_run(T_ACT + int'($urandom_range(8)), 30, 4'b0);
      if ($urandom_range(3) == 0) begin
        stop_now();
        idle_run(3);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
